// File: rtl/shifter_pkg.sv
// Op encoding and the single-level shift helper for the pipelined barrel shifter.
// The SHIFT_STATUS_EN build option lives in the stage and top files.
package shifter_pkg;

    typedef enum logic [1:0] {
        SHIFT_SRL = 2'b00,
        SHIFT_SRA = 2'b01,
        SHIFT_SLL = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_op_t;

    localparam int unsigned MAX_WIDTH = 64;

    // Shifts the low `width` bits of x by amt (amt < width); bits above width come back zero.
    function automatic logic [MAX_WIDTH-1:0] shift_level(
        input logic [MAX_WIDTH-1:0] x,
        input shift_op_t            op,
        input int unsigned          amt,
        input int unsigned          width,
        input logic                 sign
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] xm;
        logic [MAX_WIDTH-1:0] res;
        mask = (width >= MAX_WIDTH) ? '1 : ((64'd1 << width) - 64'd1);
        xm   = x & mask;
        case (op)
            SHIFT_SRL: res = xm >> amt;
            SHIFT_SRA: res = (xm >> amt) | (sign ? (~(mask >> amt) & mask) : '0);
            SHIFT_SLL: res = (xm << amt) & mask;
            default:   res = ((xm >> amt) | (xm << (width - amt))) & mask;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Valid/ready operation and result bus of the pipelined barrel shifter.
// SHIFT_STATUS_EN adds the out_zero/out_carry status flags.
interface pipelined_barrel_shifter_if
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    shift_op_t          in_op;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
`ifdef SHIFT_STATUS_EN
    logic               out_zero;
    logic               out_carry;
`endif

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
`ifdef SHIFT_STATUS_EN
        , input out_zero, out_carry
`endif
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
`ifdef SHIFT_STATUS_EN
        , output out_zero, out_carry
`endif
    );

endinterface

// File: rtl/shifter_stage.sv
// One barrel-shifter level: conditional shift by 2**LEVEL followed by its pipeline register.
// With SHIFT_STATUS_EN the last shifted-out bit is carried along as well.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter  int unsigned WIDTH   = 32,
    parameter  int unsigned TAG_W   = 4,
    parameter  int unsigned LEVEL   = 0,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance_i,
    input  logic               valid_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  shift_op_t          op_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               sign_i,
`ifdef SHIFT_STATUS_EN
    input  logic               carry_i,
    output logic               carry_o,
`endif
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o,
    output logic [SHAMT_W-1:0] shamt_o,
    output shift_op_t          op_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic               sign_o
);
    localparam int unsigned STEP = 1 << LEVEL;

    logic               valid_q;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] shamt_q;
    shift_op_t          op_q;
    logic [TAG_W-1:0]   tag_q;
    logic               sign_q;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        data_d = data_i;
        if (shamt_i[LEVEL]) begin
            data_d = WIDTH'(shift_level(MAX_WIDTH'(data_i), op_i, STEP, WIDTH, sign_i));
        end
    end

`ifdef SHIFT_STATUS_EN
    logic carry_q, carry_d;

    // The highest level that actually shifts overwrites the carry, leaving the last bit out.
    always_comb begin
        carry_d = carry_i;
        if (shamt_i[LEVEL] && (op_i != SHIFT_ROR)) begin
            carry_d = (op_i == SHIFT_SLL) ? data_i[WIDTH-STEP] : data_i[STEP-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else if (advance_i && valid_i) begin
            carry_q <= carry_d;
        end
    end

    assign carry_o = carry_q;
`endif

    // NOTE: state is updated with non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: payload registers are cleared too, so the final stage presents zero data/tag after reset.
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= SHIFT_SRL;
            tag_q   <= '0;
            sign_q  <= 1'b0;
        end else if (advance_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q  <= data_d;
                shamt_q <= shamt_i;
                op_q    <= op_i;
                tag_q   <= tag_i;
                sign_q  <= sign_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign op_o    = op_q;
    assign tag_o   = tag_q;
    assign sign_o  = sign_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (SRL/SRA/SLL/ROR), one registered level per shift-amount bit.
// Define SHIFT_STATUS_EN to add the out_zero/out_carry result flags.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input logic                     clk,
    input logic                     reset,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    // Index k feeds stage k; index k+1 is the register of stage k.
    logic               valid_s [SHAMT_W+1];
    logic [WIDTH-1:0]   data_s  [SHAMT_W+1];
    logic [SHAMT_W-1:0] shamt_s [SHAMT_W+1];
    shift_op_t          op_s    [SHAMT_W+1];
    logic [TAG_W-1:0]   tag_s   [SHAMT_W+1];
    logic               sign_s  [SHAMT_W+1];
    logic [SHAMT_W-1:0] adv;

    assign valid_s[0] = bus.in_valid;
    assign data_s[0]  = bus.in_data;
    assign shamt_s[0] = bus.in_shamt;
    assign op_s[0]    = bus.in_op;
    assign tag_s[0]   = bus.in_tag;
    assign sign_s[0]  = bus.in_data[WIDTH-1];

    // A stage advances when it, or any stage after it, is empty, or when the output drains.
    always_comb begin
        logic room;
        room = !bus.out_valid || bus.out_ready;
        adv  = '0;
        for (int k = SHAMT_W - 1; k >= 0; k--) begin
            room   = room || !valid_s[k+1];
            adv[k] = room;
        end
    end

`ifdef SHIFT_STATUS_EN
    logic carry_s [SHAMT_W+1];
    assign carry_s[0] = 1'b0;
`endif

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .LEVEL (k)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .advance_i (adv[k]),
            .valid_i   (valid_s[k]),
            .data_i    (data_s[k]),
            .shamt_i   (shamt_s[k]),
            .op_i      (op_s[k]),
            .tag_i     (tag_s[k]),
            .sign_i    (sign_s[k]),
`ifdef SHIFT_STATUS_EN
            .carry_i   (carry_s[k]),
            .carry_o   (carry_s[k+1]),
`endif
            .valid_o   (valid_s[k+1]),
            .data_o    (data_s[k+1]),
            .shamt_o   (shamt_s[k+1]),
            .op_o      (op_s[k+1]),
            .tag_o     (tag_s[k+1]),
            .sign_o    (sign_s[k+1])
        );
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = valid_s[SHAMT_W];
    assign bus.out_data  = data_s[SHAMT_W];
    assign bus.out_tag   = tag_s[SHAMT_W];

`ifdef SHIFT_STATUS_EN
    assign bus.out_carry = carry_s[SHAMT_W];
    assign bus.out_zero  = bus.out_valid && (bus.out_data == '0);
`endif

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined barrel shifter. One mux level per shift-amount bit, each level followed by a pipeline register.
- Supports logical right, arithmetic right, logical left and rotate right.
- Sits between the ALU operand-select logic and writeback.
- Uses a valid/ready handshake so downstream back-pressure stalls the pipe without losing operations.

Parameters:
- WIDTH, 32, data width in bits; power of two, 8 to 64.
- SHAMT_W, $clog2(WIDTH), shift-amount width. Derived; do not override.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  block accepts the operation this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount. Only the low SHAMT_W bits exist, no masking needed.
- in_op  in  2  00 SRL, 01 SRA, 10 SLL, 11 ROR.
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result this cycle.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Pipeline structure:
  - SHAMT_W stages; stage k conditionally shifts by 2^k, applied in order k = 0 to SHAMT_W-1.
  - Stage k registers: partial data, remaining shamt bits, op, tag, valid bit.
- Latency and throughput:
  - Latency is exactly SHAMT_W cycles from accept (in_valid && in_ready) to out_valid, with no stall (5 cycles at WIDTH=32).
  - Throughput is one operation per cycle.
- Fill per op:
  - SRL fills with 0.
  - SRA fills with the operand MSB, captured at stage 0 and carried down the pipe.
  - SLL fills with 0 from the LSB.
  - ROR wraps the bits shifted out back into the MSBs.
- Shift amount 0: output equals input for every op.
- Shift amount WIDTH-1 is the maximum:
  - SRL yields bit0 = in_data[MSB].
  - SRA yields all bits = MSB.
- Handshake:
  - Stage k advances when it is empty or stage k+1 advances.
  - The last stage advances when out_valid == 0 or out_ready == 1.
  - in_ready = stage-0 advance condition. Bubbles collapse: an empty stage accepts even while the output is stalled.
  - While out_valid && !out_ready, out_data and out_tag hold stable.
  - in_valid is sampled only with in_ready; data offered while in_ready == 0 is ignored (no implicit capture).
- Reset:
  - All valid bits clear. out_valid = 0, out_data = 0, out_tag = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
  - Reset mid-operation discards every in-flight operation; no partial result is emitted.
  - Data registers may be reset or not, except out_data/out_tag, which must read 0 after reset.
- Simultaneous accept and emit in the same cycle is legal and must not drop or duplicate an operation.

Optional Feature:
- Macro SHIFT_STATUS_EN.
- When defined, two extra outputs are added:
  - out_zero (1 bit): out_data == 0.
  - out_carry (1 bit): last bit shifted out. It is 0 for shamt 0 and for ROR, in_data[shamt-1] for SRL/SRA, and in_data[WIDTH-shamt] for SLL.
- Both flags are pipelined with the data, so they are valid exactly when out_valid is, and held under stall.
- Both are 0 after reset.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package shifter_pkg holds:
  - the op encoding constants (SHIFT_SRL, SHIFT_SRA, SHIFT_SLL, SHIFT_ROR);
  - a typedef for the 2-bit op;
  - a function computing the per-level shift of one stage, for reuse by the bench reference model.
- Sub-module shifter_stage: one level (parameter LEVEL), i.e. the mux for shift-by-2^LEVEL plus its pipeline register and valid/advance logic.
- The top generates SHAMT_W instances.

Test Plan:
- Reset, then a single SRA with in_data=32'h8000_0010, shamt=4 → out_data=32'hF800_0001 exactly 5 cycles after accept; out_tag matches.
- Back-to-back stream: SRL 32'hFFFF_FFFF by 31 → 32'h0000_0001, then SLL 32'h1 by 31 → 32'h8000_0000, then ROR 32'h0000_00F1 by 4 → 32'h1000_000F. Results come on consecutive cycles, in order.
- Stall: hold out_ready=0 for 8 cycles with in_valid=1 → after fill, in_ready drops; exactly 5 operations are in flight; out_data is stable; all results appear in order once out_ready=1, none lost.
- Bubble collapse: one operation, then 3 idle cycles, then out_ready=0 → in_ready stays 1 until the pipe is actually full.
- Reset asserted with 3 operations in flight → out_valid=0 the next cycle; no stale result appears after release.
- With SHIFT_STATUS_EN: SLL 32'h8000_0001 by 1 → out_data=32'h0000_0002, out_carry=1, out_zero=0; SRL 32'h1 by 1 → out_data=0, out_carry=1, out_zero=1.
